// File: rtl/me_sad_min.sv
// SAD accumulator and best-match selector for motion estimation.
// Two-stage |cur-ref| / row-sum pipeline feeding a strict less-than minimum tracker.
module me_sad_min #(
  parameter int PIX_W = 8,
  parameter int NPIX  = 8,
  parameter int ROWS  = 8,
  parameter int MV_W  = 5,
  localparam int SAD_W = PIX_W + $clog2(NPIX * ROWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  row_valid,
  input  logic [PIX_W*NPIX-1:0] cur_row,
  input  logic [PIX_W*NPIX-1:0] ref_row,
  input  logic [MV_W-1:0]       cand_mvx,
  input  logic [MV_W-1:0]       cand_mvy,
  input  logic                  cand_last,
  output logic                  busy,
  output logic                  done,
  output logic [SAD_W-1:0]      best_sad,
  output logic [MV_W-1:0]       best_mvx,
  output logic [MV_W-1:0]       best_mvy
);
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(ROWS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             accept_s;
  logic [SAD_W-1:0] row_sum_s;

  logic             s1_vld_q, s1_vld_d, s1_first_q, s1_first_d;
  logic             s1_close_q, s1_close_d, s1_last_q, s1_last_d;
  logic [PIX_W-1:0] s1_diff_q [NPIX];
  logic [PIX_W-1:0] s1_diff_d [NPIX];
  logic [MV_W-1:0]  s1_mvx_q, s1_mvx_d, s1_mvy_q, s1_mvy_d;

  logic             s2_close_q, s2_close_d, s2_last_q, s2_last_d;
  logic [MV_W-1:0]  s2_mvx_q, s2_mvx_d, s2_mvy_q, s2_mvy_d;
  logic [SAD_W-1:0] acc_q, acc_d;

  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [MV_W-1:0]  best_mvx_q, best_mvx_d, best_mvy_q, best_mvy_d;

  // Next-state logic for the FSM and both pipeline stages.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    accept_s   = 1'b0;
    best_sad_d = best_sad_q;
    best_mvx_d = best_mvx_q;
    best_mvy_d = best_mvy_q;

    row_sum_s = {SAD_W{1'b0}};
    for (int i = 0; i < NPIX; i++) begin
      row_sum_s = row_sum_s + SAD_W'(s1_diff_q[i]);
    end

    // A candidate's first row restarts the accumulator, so no clear is needed between candidates.
    if (s1_vld_q) begin
      acc_d = s1_first_q ? row_sum_s : (acc_q + row_sum_s);
    end else begin
      acc_d = acc_q;
    end

    if (s2_close_q && (acc_q < best_sad_q)) begin
      best_sad_d = acc_q;
      best_mvx_d = s2_mvx_q;
      best_mvy_d = s2_mvy_q;
    end else begin
      best_sad_d = best_sad_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          busy_d     = 1'b1;
          row_cnt_d  = {CNT_W{1'b0}};
          acc_d      = {SAD_W{1'b0}};
          best_sad_d = {SAD_W{1'b1}};
          best_mvx_d = {MV_W{1'b0}};
          best_mvy_d = {MV_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        accept_s = row_valid;
        if (row_valid) begin
          row_cnt_d = (row_cnt_q == LAST_ROW) ? {CNT_W{1'b0}} : (row_cnt_q + CNT_W'(1));
          state_d   = ((row_cnt_q == LAST_ROW) && cand_last) ? DRAIN : RUN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // The final candidate reaches the compare stage exactly when its tag leaves S2.
        if (s2_close_q && s2_last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    s1_vld_d   = accept_s;
    s1_first_d = (row_cnt_q == {CNT_W{1'b0}});
    s1_close_d = (row_cnt_q == LAST_ROW);
    s1_last_d  = cand_last;
    s1_mvx_d   = cand_mvx;
    s1_mvy_d   = cand_mvy;
    for (int i = 0; i < NPIX; i++) begin
      s1_diff_d[i] = abs_diff(cur_row[i*PIX_W +: PIX_W], ref_row[i*PIX_W +: PIX_W]);
    end

    s2_close_d = s1_vld_q & s1_close_q;
    s2_last_d  = s1_last_q;
    s2_mvx_d   = s1_mvx_q;
    s2_mvy_d   = s1_mvy_q;
  end

  // State, pipeline and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      row_cnt_q  <= {CNT_W{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_close_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mvx_q   <= {MV_W{1'b0}};
      s1_mvy_q   <= {MV_W{1'b0}};
      s1_diff_q  <= '{default: {PIX_W{1'b0}}};
      s2_close_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_mvx_q   <= {MV_W{1'b0}};
      s2_mvy_q   <= {MV_W{1'b0}};
      acc_q      <= {SAD_W{1'b0}};
      best_sad_q <= {SAD_W{1'b1}};
      best_mvx_q <= {MV_W{1'b0}};
      best_mvy_q <= {MV_W{1'b0}};
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_close_q <= s1_close_d;
      s1_last_q  <= s1_last_d;
      s1_mvx_q   <= s1_mvx_d;
      s1_mvy_q   <= s1_mvy_d;
      s1_diff_q  <= s1_diff_d;
      s2_close_q <= s2_close_d;
      s2_last_q  <= s2_last_d;
      s2_mvx_q   <= s2_mvx_d;
      s2_mvy_q   <= s2_mvy_d;
      acc_q      <= acc_d;
      best_sad_q <= best_sad_d;
      best_mvx_q <= best_mvx_d;
      best_mvy_q <= best_mvy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign best_sad = best_sad_q;
  assign best_mvx = best_mvx_q;
  assign best_mvy = best_mvy_q;

endmodule

// File: tb/tb_me_sad_min.sv
// Directed, scoreboard-based bench for me_sad_min: expected results are queued
// at stimulus time and compared whenever done pulses.
module tb_me_sad_min;
  logic        clk = 1'b0;
  logic        reset, start, row_valid, cand_last;
  logic [63:0] cur_row, ref_row;
  logic [4:0]  cand_mvx, cand_mvy;
  logic        busy, done;
  logic [13:0] best_sad;
  logic [4:0]  best_mvx, best_mvy;

  always #5 clk = ~clk;

  me_sad_min dut (
    .clk(clk), .reset(reset), .start(start), .row_valid(row_valid),
    .cur_row(cur_row), .ref_row(ref_row), .cand_mvx(cand_mvx), .cand_mvy(cand_mvy),
    .cand_last(cand_last), .busy(busy), .done(done), .best_sad(best_sad),
    .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  typedef struct packed {
    logic [13:0] sad;
    logic [4:0]  mvx;
    logic [4:0]  mvy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  bit   done_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, scoreboard popped on done.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    done_seen = (done === 1'b1);
    if (done_seen) begin
      done_cyc = cyc;
      chk("sb_has_entry_at_done", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("best_sad", 32'(best_sad), 32'(e.sad));
        chk("best_mvx", 32'(best_mvx), 32'(e.mvx));
        chk("best_mvy", 32'(best_mvy), 32'(e.mvy));
        chk("busy_low_at_done", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic drive_row(input logic v, input logic [63:0] c, input logic [63:0] r,
                           input logic [4:0] mx, input logic [4:0] my, input logic l);
    row_valid = v; cur_row = c; ref_row = r; cand_mvx = mx; cand_mvy = my; cand_last = l;
    step();
  endtask

  // One candidate: row 0 uses r0, rows 1..7 use rn; tags are junk except on the closing row.
  task automatic send_cand(input logic [63:0] c, input logic [63:0] r0, input logic [63:0] rn,
                           input logic [4:0] mx, input logic [4:0] my, input logic l,
                           input bit gaps);
    for (int r = 0; r < 8; r++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++)
          drive_row(1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 5'h15, 5'h0A, 1'b1);
      end
      drive_row(1'b1, c, (r == 0) ? r0 : rn, (r == 7) ? mx : 5'h0A,
                (r == 7) ? my : 5'h15, (r == 7) ? l : 1'b1);
    end
    row_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int k;
    k = 0;
    done_seen = 1'b0;
    while (!done_seen && k < 30) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_latency"}, 32'(k), 32'(exp_lat));
    step();
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  function automatic int row_sad(input logic [63:0] c, input logic [63:0] r);
    int s, a, b;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      a = int'(c[8*i +: 8]);
      b = int'(r[8*i +: 8]);
      s += (a > b) ? (a - b) : (b - a);
    end
    return s;
  endfunction

  initial begin
    int t0, sa, sbv;
    logic [63:0] ca, ra, cb, rb;
    exp_t e4;

    reset = 1'b1; start = 1'b0; row_valid = 1'b0; cur_row = '0; ref_row = '0;
    cand_mvx = '0; cand_mvy = '0; cand_last = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_best_sad", 32'(best_sad), 32'h3FFF);
    chk("rst_best_mvx", 32'(best_mvx), 32'd0);
    chk("rst_best_mvy", 32'(best_mvy), 32'd0);
    reset = 1'b0;
    step();

    // Single candidate, diff 2 per pixel.
    pulse_start();
    t0 = cyc;
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    sb.push_back(exp_t'{sad: 14'd128, mvx: 5'd3, mvy: 5'h1E});
    send_cand({8{8'h10}}, {8{8'h12}}, {8{8'h12}}, 5'd3, 5'h1E, 1'b1, 1'b0);
    wait_done("t1", 2);
    chk("t1_start_to_done", 32'(done_cyc - t0), 32'd10);

    // Maximum magnitude, extreme motion vectors.
    pulse_start();
    sb.push_back(exp_t'{sad: 14'd16320, mvx: 5'h10, mvy: 5'h0F});
    send_cand({8{8'hFF}}, {8{8'h00}}, {8{8'h00}}, 5'h10, 5'h0F, 1'b1, 1'b0);
    wait_done("t2", 2);
    step(); step(); step();
    chk("t2_hold_sad", 32'(best_sad), 32'd16320);
    chk("t2_hold_mvx", 32'(best_mvx), 32'h10);
    chk("t2_hold_busy", 32'(busy), 32'd0);

    // SADs 200, 64, 64: tie keeps the first 64; a row during DRAIN is dropped.
    pulse_start();
    sb.push_back(exp_t'{sad: 14'd64, mvx: 5'd1, mvy: 5'd0});
    send_cand({8{8'h10}}, {8{8'h14}}, {8{8'h13}}, 5'd0, 5'd0, 1'b0, 1'b0);
    send_cand({8{8'h10}}, {8{8'h11}}, {8{8'h11}}, 5'd1, 5'd0, 1'b0, 1'b0);
    send_cand({8{8'h10}}, {8{8'h11}}, {8{8'h11}}, 5'd2, 5'd0, 1'b1, 1'b0);
    drive_row(1'b1, {8{8'h00}}, {8{8'hFF}}, 5'd9, 5'd9, 1'b1);
    row_valid = 1'b0;
    wait_done("t3", 1);

    // Two random candidates, gap-free then with random row_valid gaps.
    ca = {$urandom, $urandom}; ra = {$urandom, $urandom};
    cb = {$urandom, $urandom}; rb = {$urandom, $urandom};
    sa  = 8 * row_sad(ca, ra);
    sbv = 8 * row_sad(cb, rb);
    e4 = (sbv < sa) ? exp_t'{sad: 14'(sbv), mvx: 5'h1F, mvy: 5'd4}
                    : exp_t'{sad: 14'(sa), mvx: 5'd6, mvy: 5'h1C};
    pulse_start();
    sb.push_back(e4);
    send_cand(ca, ra, ra, 5'd6, 5'h1C, 1'b0, 1'b0);
    send_cand(cb, rb, rb, 5'h1F, 5'd4, 1'b1, 1'b0);
    wait_done("t4_nogap", 2);
    pulse_start();
    sb.push_back(e4);
    send_cand(ca, ra, ra, 5'd6, 5'h1C, 1'b0, 1'b1);
    send_cand(cb, rb, rb, 5'h1F, 5'd4, 1'b1, 1'b1);
    wait_done("t4_gap", 2);

    // Reset mid-candidate after four rows, then a fresh search.
    pulse_start();
    for (int r = 0; r < 4; r++) drive_row(1'b1, {8{8'hFF}}, {8{8'h00}}, 5'd7, 5'd7, 1'b0);
    row_valid = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_busy_in_reset", 32'(busy), 32'd0);
    chk("t5_done_in_reset", 32'(done), 32'd0);
    chk("t5_sad_in_reset", 32'(best_sad), 32'h3FFF);
    step();
    reset = 1'b0;
    step();
    pulse_start();
    sb.push_back(exp_t'{sad: 14'd64, mvx: 5'd2, mvy: 5'd3});
    send_cand({8{8'h10}}, {8{8'h11}}, {8{8'h11}}, 5'd2, 5'd3, 1'b1, 1'b0);
    wait_done("t5", 2);

    // start during RUN and row_valid in IDLE are ignored.
    pulse_start();
    sb.push_back(exp_t'{sad: 14'd128, mvx: 5'd4, mvy: 5'd4});
    for (int r = 0; r < 3; r++) drive_row(1'b1, {8{8'h10}}, {8{8'h12}}, 5'd0, 5'd0, 1'b0);
    start = 1'b1;
    drive_row(1'b0, {8{8'hFF}}, {8{8'h00}}, 5'd0, 5'd0, 1'b0);
    start = 1'b0;
    chk("t6_busy_after_restart", 32'(busy), 32'd1);
    for (int r = 3; r < 8; r++)
      drive_row(1'b1, {8{8'h10}}, {8{8'h12}}, 5'd4, 5'd4, (r == 7) ? 1'b1 : 1'b0);
    row_valid = 1'b0;
    wait_done("t6", 2);
    for (int r = 0; r < 3; r++) drive_row(1'b1, {8{8'hFF}}, {8{8'h00}}, 5'd7, 5'd7, 1'b1);
    row_valid = 1'b0;
    step();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_sad", 32'(best_sad), 32'd128);
    chk("t6_idle_mvx", 32'(best_mvx), 32'd4);
    pulse_start();
    sb.push_back(exp_t'{sad: 14'd64, mvx: 5'h1F, mvy: 5'd1});
    send_cand({8{8'h10}}, {8{8'h11}}, {8{8'h11}}, 5'h1F, 5'd1, 1'b1, 1'b0);
    wait_done("t6_after", 2);

    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
